dram_read_master: RTL

- AXI4 read master between the image pipeline's DRAM read request interface and the PS DDR slave port.
- Accepts a single-cycle read request (start address, beat count), issues one or two INCR bursts, and streams returned 128-bit beats back to the image FIFO.
- Honours the FIFO's buffer-full backpressure.
- Splits any request that crosses a 4 KB boundary, as AXI4 requires.

---
 rtl/dram_pkg.sv | 19 +
 rtl/dram_read_master.sv | 127 ++++++++++++
 2 files changed

// File: rtl/dram_pkg.sv
// Shared types and constants for the DRAM AXI4 read master.
// Optional error counter in the top is enabled by DRAM_READ_MASTER_ERR_CNT_EN.
package dram_pkg;

  typedef enum logic [1:0] {IDLE, AR, R} state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int         BOUNDARY_4K    = 4096;

  // Whole beats that fit between a beat-aligned offset and the next 4 KB page.
  function automatic logic [12:0] beats_to_boundary(input logic [11:0] addr,
                                                    input logic [12:0] beat_bytes);
    logic [12:0] gap;
    gap = 13'(BOUNDARY_4K) - {1'b0, addr};
    return gap / beat_bytes;
  endfunction

endpackage

// File: rtl/dram_read_master.sv
// AXI4 read master: one request becomes one or two INCR bursts (split at 4 KB),
// beats stream to the image FIFO. Macro DRAM_READ_MASTER_ERR_CNT_EN adds rd_err_count.
module dram_read_master
  import dram_pkg::*;
#(
  parameter int DRAM_ADDR_WIDTH = 39,
  parameter int DRAM_DATA_WIDTH = 128,
  parameter int AXI_ID_WIDTH    = 16
) (
  input  logic                       s_axi_aclk,
  input  logic                       s_axi_aresetn,
  input  logic [DRAM_ADDR_WIDTH-1:0] dram_read_addr,
  input  logic [7:0]                 dram_read_len,
  input  logic                       dram_read_en,
  input  logic                       dram_buffer_full,
  output logic [DRAM_DATA_WIDTH-1:0] dram_read_data,
  output logic                       dram_read_data_valid,
  output logic                       dram_read_busy,
  output logic [DRAM_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                 m_axi_arlen,
  output logic [2:0]                 m_axi_arsize,
  output logic [1:0]                 m_axi_arburst,
  output logic [AXI_ID_WIDTH-1:0]    m_axi_arid,
  output logic                       m_axi_arvalid,
  input  logic                       m_axi_arready,
  input  logic [DRAM_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                 m_axi_rresp,
  input  logic                       m_axi_rlast,
  input  logic                       m_axi_rvalid,
`ifdef DRAM_READ_MASTER_ERR_CNT_EN
  output logic [15:0]                rd_err_count,
`endif
  output logic                       m_axi_rready,
  input  logic [AXI_ID_WIDTH-1:0]    m_axi_rid
);

  localparam int BEAT_BYTES = DRAM_DATA_WIDTH / 8;
  localparam int HI_W       = DRAM_ADDR_WIDTH - 12;

  state_t                     state, state_nxt;
  logic [DRAM_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                 ar_len;
  logic [8:0]                 remaining;
  logic [8:0]                 req_beats;
  logic [12:0]                to_bound;
  logic [8:0]                 first_beats;
  logic                       r_hs;

  assign req_beats   = {1'b0, dram_read_len} + 9'd1;
  assign to_bound    = beats_to_boundary(dram_read_addr[11:0], 13'(BEAT_BYTES));
  assign first_beats = ({4'b0, req_beats} < to_bound) ? req_beats : to_bound[8:0];
  assign r_hs        = m_axi_rvalid && m_axi_rready;

  assign m_axi_araddr   = ar_addr;
  assign m_axi_arlen    = ar_len;
  assign m_axi_arsize   = 3'($clog2(BEAT_BYTES));
  assign m_axi_arburst  = AXI_BURST_INCR;
  assign m_axi_arid     = '0;
  assign dram_read_busy = (state != IDLE);

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) state <= IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    case (state)
      IDLE: if (dram_read_en) state_nxt = AR;
      AR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_nxt = R;
      end
      R: begin
        m_axi_rready = !dram_buffer_full;
        // rlast alone terminates the burst, whatever the beat count says
        if (r_hs && m_axi_rlast) state_nxt = (remaining == 9'd0) ? IDLE : AR;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      ar_addr              <= '0;
      ar_len               <= '0;
      remaining            <= '0;
      dram_read_data       <= '0;
      dram_read_data_valid <= 1'b0;
    end else begin
      dram_read_data_valid <= r_hs;
      if (r_hs) dram_read_data <= m_axi_rdata;
      if (state == IDLE && dram_read_en) begin
        ar_addr   <= dram_read_addr;
        ar_len    <= 8'(first_beats - 9'd1);
        remaining <= req_beats - first_beats;
      end else if (state == R && r_hs && m_axi_rlast && remaining != 9'd0) begin
        // second burst starts on the next page; upper bits wrap naturally
        ar_addr   <= {ar_addr[DRAM_ADDR_WIDTH-1:12] + HI_W'(1), 12'h000};
        ar_len    <= 8'(remaining - 9'd1);
        remaining <= '0;
      end
    end
  end

`ifdef DRAM_READ_MASTER_ERR_CNT_EN
  logic [1:0]  err_inc;
  logic [16:0] err_sum;
  assign err_inc = 2'(r_hs && (m_axi_rresp != AXI_RESP_OKAY))
                 + 2'(dram_read_en && (state != IDLE));
  assign err_sum = {1'b0, rd_err_count} + 17'(err_inc);

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) rd_err_count <= '0;
    else                rd_err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  logic unused_rid;
  assign unused_rid = ^m_axi_rid;
`else
  logic unused_rid;
  assign unused_rid = ^{m_axi_rid, m_axi_rresp};
`endif

endmodule
